uart_rx_pkt_ctrl: RTL and testbench



---
 rtl/uart_rx_pkt_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_pkt_ctrl
//   Packet controller behind a UART receiver. Hunts for SYNC_BYTE, takes a
//   length byte, buffers the payload and checks an XOR checksum that covers
//   the length byte and all payload bytes. A validated packet is held and
//   read out one byte per rd_en_i. Inter-byte gaps longer than TIMEOUT
//   abort the packet.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   rx_data_i     : received byte (valid when rx_valid_i=1)
//   rx_valid_i    : one-cycle byte strobe
//   rd_en_i       : pop the current payload byte
//   pkt_ready_o   : validated packet held and readable
//   pkt_len_o     : payload length of the held packet
//   rd_data_o     : current payload byte (0 when no packet held)
//   rd_last_o     : current byte is the final payload byte
//   err_o         : one-cycle framing error pulse
//   err_code_o    : last error (0 none, 1 length, 2 checksum, 3 timeout)
//   overrun_o     : one-cycle pulse when a byte is dropped while holding
//   pkt_cnt_o     : good packet count, wraps
// ---------------------------------------------------------------------------
module uart_rx_pkt_ctrl #(
  parameter int unsigned MAX_LEN   = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rd_en_i,
  output logic        pkt_ready_o,
  output logic [7:0]  pkt_len_o,
  output logic [7:0]  rd_data_o,
  output logic        rd_last_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        overrun_o,
  output logic [15:0] pkt_cnt_o
);

  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] GAP_LIMIT = TIMEOUT - 16'd1;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_LEN     = 5'b00010,
    S_PAYLOAD = 5'b00100,
    S_CSUM    = 5'b01000,
    S_HOLD    = 5'b10000
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]  pkt_buf [MAX_LEN];
  logic [7:0]  rd_ptr;
  logic [7:0]  wr_idx;
  logic [7:0]  csum;
  logic [15:0] gap;

  // Decoded events for the current cycle
  logic in_frame;
  logic byte_in;
  logic timeout_hit;
  logic len_bad;
  logic len_good;
  logic pay_wr;
  logic pay_last;
  logic csum_good;
  logic csum_bad;
  logic pop;
  logic pop_last;
  logic overrun_hit;
  logic err_hit;
  logic [1:0] err_code_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (byte_in && rx_data_i == SYNC_BYTE) begin
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (len_bad || timeout_hit) begin
          state_nxt = S_IDLE;
        end else if (len_good) begin
          state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (timeout_hit) begin
          state_nxt = S_IDLE;
        end else if (pay_last) begin
          state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (csum_bad || timeout_hit) begin
          state_nxt = S_IDLE;
        end else if (csum_good) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pop_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Event decode and read-side outputs
  always_comb begin
    byte_in      = rx_valid_i;
    in_frame     = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // A byte on the limit cycle takes priority over the timeout
    timeout_hit  = in_frame && !rx_valid_i && (gap == GAP_LIMIT);
    len_bad      = byte_in && (state == S_LEN) &&
                   ((rx_data_i == 8'd0) || (rx_data_i > MAX_LEN_B));
    len_good     = byte_in && (state == S_LEN) && !len_bad;
    pay_wr       = byte_in && (state == S_PAYLOAD);
    pay_last     = pay_wr && (wr_idx == pkt_len_o - 8'd1);
    csum_good    = byte_in && (state == S_CSUM) && (rx_data_i == csum);
    csum_bad     = byte_in && (state == S_CSUM) && (rx_data_i != csum);
    overrun_hit  = byte_in && (state == S_HOLD);

    pkt_ready_o  = (state == S_HOLD);
    rd_last_o    = pkt_ready_o && (rd_ptr == pkt_len_o - 8'd1);
    rd_data_o    = pkt_ready_o ? pkt_buf[AW'(rd_ptr)] : 8'h00;
    pop          = rd_en_i && pkt_ready_o;
    pop_last     = pop && rd_last_o;

    err_hit      = len_bad || csum_bad || timeout_hit;
    err_code_nxt = 2'd0;
    if (len_bad) begin
      err_code_nxt = ERR_LEN;
    end else if (csum_bad) begin
      err_code_nxt = ERR_CSUM;
    end else if (timeout_hit) begin
      err_code_nxt = ERR_TIMEOUT;
    end
  end

  // Control datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_len_o  <= 8'd0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
      overrun_o  <= 1'b0;
      pkt_cnt_o  <= 16'd0;
      rd_ptr     <= 8'd0;
      wr_idx     <= 8'd0;
      csum       <= 8'd0;
      gap        <= 16'd0;
    end else begin
      err_o     <= err_hit;
      overrun_o <= overrun_hit;
      if (err_hit) begin
        err_code_o <= err_code_nxt;
      end

      // Gap counter only runs while a packet is being framed
      if (!in_frame || rx_valid_i) begin
        gap <= 16'd0;
      end else begin
        gap <= gap + 16'd1;
      end

      if (len_good) begin
        pkt_len_o <= rx_data_i;
        csum      <= rx_data_i;
        wr_idx    <= 8'd0;
      end

      if (pay_wr) begin
        csum   <= csum ^ rx_data_i;
        wr_idx <= wr_idx + 8'd1;
      end

      if (csum_good) begin
        rd_ptr    <= 8'd0;
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      end

      if (pop) begin
        rd_ptr <= pop_last ? 8'd0 : rd_ptr + 8'd1;
      end
    end
  end

  // Payload storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (pay_wr) begin
      pkt_buf[AW'(wr_idx)] <= rx_data_i;
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
//   Self-checking bench. Payload bytes expected from each good packet are
//   queued as the packet is sent and popped as the consumer reads them.
// ---------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam logic [15:0] TIMEOUT = 16'd20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rd_en_i;
  logic        pkt_ready_o;
  logic [7:0]  pkt_len_o;
  logic [7:0]  rd_data_o;
  logic        rd_last_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        overrun_o;
  logic [15:0] pkt_cnt_o;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(
    .MAX_LEN  (MAX_LEN),
    .SYNC_BYTE(SYNC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rd_en_i    (rd_en_i),
    .pkt_ready_o(pkt_ready_o),
    .pkt_len_o  (pkt_len_o),
    .rd_data_o  (rd_data_o),
    .rd_last_o  (rd_last_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .overrun_o  (overrun_o),
    .pkt_cnt_o  (pkt_cnt_o)
  );

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int exp_err = 0;
  int exp_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] pl [$];

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (err_o) err_seen++;
    if (overrun_o) ovr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  // Sends SYNC, length, pl and checksum; good packets queue their payload
  task automatic send_pkt();
    logic [7:0] c;
    c = 8'(pl.size());
    send_byte(SYNC);
    send_byte(c);
    foreach (pl[i]) begin
      send_byte(pl[i]);
      c = c ^ pl[i];
      exp_q.push_back(pl[i]);
    end
    check("ready_pre_csum", 32'(pkt_ready_o), 32'd0);
    send_byte(c);
  endtask

  // Pops the held packet; optionally strobes a byte on the final pop
  task automatic drain(input bit rx_on_last, input logic [7:0] last_rx);
    logic [7:0] e;
    check("ready_before_read", 32'(pkt_ready_o), 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_data", 32'(rd_data_o), 32'(e));
      check("rd_last", 32'(rd_last_o), 32'(exp_q.size() == 0));
      rd_en_i = 1'b1;
      if (rx_on_last && exp_q.size() == 0) begin
        rx_data_i  = last_rx;
        rx_valid_i = 1'b1;
      end
      tick();
      rd_en_i    = 1'b0;
      rx_valid_i = 1'b0;
      if (rx_on_last && exp_q.size() == 0) begin
        check("overrun_last_pop", 32'(overrun_o), 32'd1);
      end
    end
    check("ready_after_read", 32'(pkt_ready_o), 32'd0);
    check("rd_data_idle", 32'(rd_data_o), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(pkt_ready_o), 32'd0);
    check({tag, "_len"}, 32'(pkt_len_o), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data_o), 32'd0);
    check({tag, "_rd_last"}, 32'(rd_last_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_err_code"}, 32'(err_code_o), 32'd0);
    check({tag, "_overrun"}, 32'(overrun_o), 32'd0);
    check({tag, "_cnt"}, 32'(pkt_cnt_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    rd_en_i    = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: good packet
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt();
    exp_cnt++;
    check("t1_ready", 32'(pkt_ready_o), 32'd1);
    check("t1_len", 32'(pkt_len_o), 32'd3);
    check("t1_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));
    drain(1'b0, 8'h00);
    check("t1_err_seen", 32'(err_seen), 32'(exp_err));

    // 2: bad checksum (expected 32)
    send_byte(SYNC);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'hFF);
    exp_err++;
    check("t2_err", 32'(err_o), 32'd1);
    check("t2_code", 32'(err_code_o), 32'd2);
    check("t2_ready", 32'(pkt_ready_o), 32'd0);
    check("t2_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));
    tick();
    check("t2_err_pulse", 32'(err_o), 32'd0);
    check("t2_code_hold", 32'(err_code_o), 32'd2);

    // 3: hunt, bad lengths, then good packets incl. max length
    send_byte(8'h00);
    send_byte(8'hFF);
    check("t3_hunt_err", 32'(err_seen), 32'(exp_err));
    send_byte(SYNC);
    send_byte(8'h00);
    exp_err++;
    check("t3_len0_err", 32'(err_o), 32'd1);
    check("t3_len0_code", 32'(err_code_o), 32'd1);
    send_byte(SYNC);
    send_byte(8'h11);
    exp_err++;
    check("t3_len17_err", 32'(err_o), 32'd1);
    check("t3_len17_code", 32'(err_code_o), 32'd1);
    tick();
    pl = '{8'h7E};
    send_pkt();
    exp_cnt++;
    check("t3_rd_data", 32'(rd_data_o), 32'h7E);
    check("t3_last_single", 32'(rd_last_o), 32'd1);
    drain(1'b0, 8'h00);
    pl = {};
    for (int i = 0; i < int'(MAX_LEN); i++) pl.push_back(8'(i * 17 + 1));
    send_pkt();
    exp_cnt++;
    check("t3_maxlen", 32'(pkt_len_o), 32'(MAX_LEN));
    drain(1'b0, 8'h00);
    check("t3_err_seen", 32'(err_seen), 32'(exp_err));
    check("t3_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

    // 4: timeout, then a byte landing on the limit cycle
    send_byte(SYNC);
    send_byte(8'h02);
    send_byte(8'h10);
    repeat (int'(TIMEOUT) - 1) tick();
    check("t4_no_err_early", 32'(err_o), 32'd0);
    tick();
    exp_err++;
    check("t4_timeout_err", 32'(err_o), 32'd1);
    check("t4_timeout_code", 32'(err_code_o), 32'd3);
    tick();
    check("t4_err_pulse", 32'(err_o), 32'd0);
    send_byte(SYNC);
    send_byte(8'h02);
    send_byte(8'h10);
    repeat (int'(TIMEOUT) - 1) tick();
    send_byte(8'h20);
    check("t4_limit_no_err", 32'(err_o), 32'd0);
    send_byte(8'h32);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_cnt++;
    check("t4_limit_ready", 32'(pkt_ready_o), 32'd1);
    drain(1'b0, 8'h00);
    check("t4_err_seen", 32'(err_seen), 32'(exp_err));
    check("t4_code_hold", 32'(err_code_o), 32'd3);

    // 5: overrun while holding
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt();
    exp_cnt++;
    send_byte(8'h55);
    check("t5_ovr1", 32'(overrun_o), 32'd1);
    tick();
    check("t5_ovr_pulse", 32'(overrun_o), 32'd0);
    send_byte(8'h55);
    check("t5_ovr2", 32'(overrun_o), 32'd1);
    check("t5_len_kept", 32'(pkt_len_o), 32'd3);
    drain(1'b1, SYNC);
    pl = '{8'h5A};
    send_pkt();
    exp_cnt++;
    check("t5_after_ready", 32'(pkt_ready_o), 32'd1);
    drain(1'b0, 8'h00);
    check("t5_ovr_seen", 32'(ovr_seen), 32'd3);
    check("t5_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));
    check("t5_err_seen", 32'(err_seen), 32'(exp_err));

    // 6: reset mid-payload
    send_byte(SYNC);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    tick();
    check_all_zero("t6_reset");
    rst = 1'b0;
    tick();
    check("t6_err_seen", 32'(err_seen), 32'(exp_err));
    pl = '{8'hAA, 8'hBB};
    send_pkt();
    check("t6_len", 32'(pkt_len_o), 32'd2);
    check("t6_cnt", 32'(pkt_cnt_o), 32'd1);
    drain(1'b0, 8'h00);
    check("t6_err_final", 32'(err_seen), 32'(exp_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
